counter_load_ctrl: RTL and testbench

Control sequencer that sits directly upstream of a cascaded pair of LS161a 4-bit counters forming an 8-bit counter, and drives their D, LOAD_n, ENP and ENT inputs. It also watches the counter's Q and ripple-carry output. It turns start, stop and hold commands plus a programmable preset into one-shot or auto-reload (periodic) timing. It reports terminal-count events, an event tally, an overrun flag and a load-integrity check.

---
 rtl/counter_load_ctrl_if.sv | 30 +++
 rtl/counter_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_counter_load_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_load_ctrl_if.sv
// Bus between the load/run sequencer and a cascaded LS161a counter chain.
// The master drives D/LOAD_n/ENP/ENT; the counter side returns Q and the top-stage RCO.
interface counter_load_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_load_n;
    logic             cnt_enp;
    logic             cnt_ent;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_tc;

    modport master (
        output cnt_d,
        output cnt_load_n,
        output cnt_enp,
        output cnt_ent,
        input  cnt_q,
        input  cnt_tc
    );

    modport slave (
        input  cnt_d,
        input  cnt_load_n,
        input  cnt_enp,
        input  cnt_ent,
        output cnt_q,
        output cnt_tc
    );
endinterface

// File: rtl/counter_load_ctrl.sv
// Start/stop/hold sequencer for an LS161a counter chain: one-shot or auto-reload timing,
// terminal-count pulse, saturating event tally with overrun, and a post-load integrity check.
module counter_load_ctrl #(
    parameter int WIDTH = 8,
    parameter int EVW   = 8
) (
    input  logic                 CLK,
    input  logic                 CLR_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 hold,
    input  logic                 periodic,
    input  logic                 preset_we,
    input  logic [WIDTH-1:0]     preset_in,
    input  logic                 ev_clr,
    counter_load_ctrl_if.master  cnt_bus,
    output logic                 busy,
    output logic                 tc_pulse,
    output logic [EVW-1:0]       event_count,
    output logic                 overrun,
    output logic                 load_err
);

    localparam int NIB = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             first_run_q, first_run_d;
    logic             busy_q, busy_d;
    logic             ent_q, ent_d;
    logic             load_q, load_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic [EVW-1:0]   ev_q, ev_d;
    logic             ovr_q, ovr_d;
    logic             lerr_q, lerr_d;

    logic             tc_ev;
    logic             reload;
    logic [NIB-1:0]   nib_mismatch;

    // Per-stage compare of the loaded value against the snapshot taken in LOAD.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign nib_mismatch[gi] = (cnt_bus.cnt_q[gi*4 +: 4] != exp_q[gi*4 +: 4]);
    end

    always_comb begin
        tc_ev       = (state_q == S_RUN) && !hold && cnt_bus.cnt_tc;
        reload      = tc_ev && periodic && !stop && !start;

        state_d     = state_q;
        preset_d    = preset_q;
        exp_d       = exp_q;
        ev_d        = ev_q;
        ovr_d       = ovr_q;
        lerr_d      = lerr_q;
        tc_pulse_d  = tc_ev;

        if (preset_we) begin
            preset_d = preset_in;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                exp_d   = preset_q;
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_LOAD;
                end else if (tc_ev && !periodic) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        first_run_d = (state_q == S_LOAD) && (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        ent_d       = (state_d == S_RUN);
        load_d      = (state_d == S_LOAD);

        if (ev_clr) begin
            ev_d  = tc_ev ? EVW'(1) : '0;
            ovr_d = 1'b0;
        end else if (tc_ev) begin
            if (&ev_q) begin
                ovr_d = 1'b1;
            end else begin
                ev_d = ev_q + EVW'(1);
            end
        end

        if (first_run_q && (|nib_mismatch)) begin
            lerr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q     <= S_IDLE;
            preset_q    <= '0;
            exp_q       <= '0;
            first_run_q <= 1'b0;
            busy_q      <= 1'b0;
            ent_q       <= 1'b0;
            load_q      <= 1'b0;
            tc_pulse_q  <= 1'b0;
            ev_q        <= '0;
            ovr_q       <= 1'b0;
            lerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            exp_q       <= exp_d;
            first_run_q <= first_run_d;
            busy_q      <= busy_d;
            ent_q       <= ent_d;
            load_q      <= load_d;
            tc_pulse_q  <= tc_pulse_d;
            ev_q        <= ev_d;
            ovr_q       <= ovr_d;
            lerr_q      <= lerr_d;
        end
    end

    // In one-shot mode ENP drops during the terminal cycle so the chain parks at all-ones
    // instead of wrapping; RCO depends only on ENT, so this creates no loop.
    assign cnt_bus.cnt_d      = preset_q;
    assign cnt_bus.cnt_ent    = ent_q;
    assign cnt_bus.cnt_enp    = ent_q && !hold && !(cnt_bus.cnt_tc && !periodic);
    assign cnt_bus.cnt_load_n = !(load_q || reload);

    assign busy        = busy_q;
    assign tc_pulse    = tc_pulse_q;
    assign event_count = ev_q;
    assign overrun     = ovr_q;
    assign load_err    = lerr_q;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Directed bench: a behavioural LS161a chain closes the loop around the sequencer.
module tb_counter_load_ctrl;

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic       start, stop, hold, periodic, preset_we, ev_clr;
    logic [7:0] preset_in;
    logic       busy, tc_pulse, overrun, load_err;
    logic [1:0] event_count;
    logic [7:0] cq;
    logic       force_zero;
    int         total = 0;
    int         bad   = 0;

    counter_load_ctrl_if #(.WIDTH(8)) bus ();

    counter_load_ctrl #(.WIDTH(8), .EVW(2)) dut (
        .CLK         (CLK),
        .CLR_n       (CLR_n),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .periodic    (periodic),
        .preset_we   (preset_we),
        .preset_in   (preset_in),
        .ev_clr      (ev_clr),
        .cnt_bus     (bus),
        .busy        (busy),
        .tc_pulse    (tc_pulse),
        .event_count (event_count),
        .overrun     (overrun),
        .load_err    (load_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n)                          cq <= 8'h00;
        else if (!bus.cnt_load_n)            cq <= bus.cnt_d;
        else if (bus.cnt_enp && bus.cnt_ent) cq <= cq + 8'h01;
    end

    assign bus.cnt_q  = force_zero ? 8'h00 : cq;
    assign bus.cnt_tc = bus.cnt_ent && (cq == 8'hFF);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        CLR_n = 1'b1; start = 0; stop = 0; hold = 0; periodic = 0;
        preset_we = 0; preset_in = 8'h00; ev_clr = 0; force_zero = 0;
        #1 CLR_n = 1'b0;
        #2;
        check("rst_busy",   32'(busy), 'h0);
        check("rst_load_n", 32'(bus.cnt_load_n), 'h1);
        check("rst_enp",    32'(bus.cnt_enp), 'h0);
        check("rst_ent",    32'(bus.cnt_ent), 'h0);
        check("rst_tcp",    32'(tc_pulse), 'h0);
        check("rst_ev",     32'(event_count), 'h0);
        check("rst_ovr",    32'(overrun), 'h0);
        check("rst_lerr",   32'(load_err), 'h0);
        check("rst_d",      32'(bus.cnt_d), 'h0);
        @(posedge CLK); #2 CLR_n = 1'b1;

        // periodic, preset FB: period 5
        preset_we = 1; preset_in = 8'hFB; periodic = 1; step; preset_we = 0;
        check("t1_d", 32'(bus.cnt_d), 'hFB);
        start = 1; step; start = 0;
        check("t1_load_n", 32'(bus.cnt_load_n), 'h0);
        check("t1_busy",   32'(busy), 'h1);
        check("t1_ld_enp", 32'(bus.cnt_enp), 'h0);
        step;
        check("t1_q0",     32'(bus.cnt_q), 'hFB);
        check("t1_ent",    32'(bus.cnt_ent), 'h1);
        check("t1_enp",    32'(bus.cnt_enp), 'h1);
        check("t1_ldn_hi", 32'(bus.cnt_load_n), 'h1);
        for (int i = 1; i <= 4; i++) begin
            step;
            check("t1_q", 32'(bus.cnt_q), 32'(8'hFB + i));
            check("t1_tcp0", 32'(tc_pulse), 'h0);
        end
        check("t1_tc",     32'(bus.cnt_tc), 'h1);
        check("t1_reload", 32'(bus.cnt_load_n), 'h0);
        step;
        check("t1_wrap", 32'(bus.cnt_q), 'hFB);
        check("t1_tcp",  32'(tc_pulse), 'h1);
        check("t1_ev1",  32'(event_count), 'h1);
        check("t1_lerr", 32'(load_err), 'h0);
        repeat (4) step;
        check("t1_ff2", 32'(bus.cnt_q), 'hFF);
        step;
        check("t1_tcp2", 32'(tc_pulse), 'h1);
        check("t1_ev2",  32'(event_count), 'h2);
        stop = 1; step; stop = 0;
        check("t1_stop_busy", 32'(busy), 'h0);
        check("t1_stop_ent",  32'(bus.cnt_ent), 'h0);

        // one-shot, preset FD
        ev_clr = 1; step; ev_clr = 0;
        check("t2_evclr", 32'(event_count), 'h0);
        preset_we = 1; preset_in = 8'hFD; periodic = 0; step; preset_we = 0;
        start = 1; step; start = 0;
        step;
        check("t2_q0", 32'(bus.cnt_q), 'hFD);
        step; step;
        check("t2_qff",   32'(bus.cnt_q), 'hFF);
        check("t2_enp",   32'(bus.cnt_enp), 'h0);
        check("t2_ldn",   32'(bus.cnt_load_n), 'h1);
        step;
        check("t2_tcp",   32'(tc_pulse), 'h1);
        check("t2_busy",  32'(busy), 'h0);
        check("t2_frz",   32'(bus.cnt_q), 'hFF);
        check("t2_ev",    32'(event_count), 'h1);
        step;
        check("t2_frz2",  32'(bus.cnt_q), 'hFF);
        check("t2_tcp0",  32'(tc_pulse), 'h0);

        // hold at all-ones
        preset_we = 1; preset_in = 8'hF0; periodic = 1; step; preset_we = 0;
        start = 1; step; start = 0;
        step;
        check("t3_q0", 32'(bus.cnt_q), 'hF0);
        repeat (15) step;
        check("t3_qff", 32'(bus.cnt_q), 'hFF);
        hold = 1; #1;
        check("t3_enp", 32'(bus.cnt_enp), 'h0);
        check("t3_ent", 32'(bus.cnt_ent), 'h1);
        check("t3_tc",  32'(bus.cnt_tc), 'h1);
        check("t3_ldn", 32'(bus.cnt_load_n), 'h1);
        repeat (10) begin
            step;
            check("t3_hold_tcp", 32'(tc_pulse), 'h0);
        end
        check("t3_hold_q",  32'(bus.cnt_q), 'hFF);
        check("t3_hold_ev", 32'(event_count), 'h1);
        hold = 0; #1;
        check("t3_rel_ldn", 32'(bus.cnt_load_n), 'h0);
        step;
        check("t3_rel_q",   32'(bus.cnt_q), 'hF0);
        check("t3_rel_tcp", 32'(tc_pulse), 'h1);
        check("t3_rel_ev",  32'(event_count), 'h2);
        step;
        check("t3_once", 32'(tc_pulse), 'h0);

        // collisions
        repeat (14) step;
        check("t4_qff", 32'(bus.cnt_q), 'hFF);
        stop = 1; #1;
        check("t4_ldn", 32'(bus.cnt_load_n), 'h1);
        step; stop = 0;
        check("t4_tcp",  32'(tc_pulse), 'h1);
        check("t4_busy", 32'(busy), 'h0);
        check("t4_ev",   32'(event_count), 'h3);
        start = 1; stop = 1; step; start = 0; stop = 0;
        check("t4_ss_busy", 32'(busy), 'h0);
        start = 1; step; start = 0;
        step; step; step;
        check("t4_q2", 32'(bus.cnt_q), 'hF2);
        start = 1; step; start = 0;
        check("t4_rs_ldn",  32'(bus.cnt_load_n), 'h0);
        check("t4_rs_busy", 32'(busy), 'h1);
        step;
        check("t4_rs_q", 32'(bus.cnt_q), 'hF0);
        stop = 1; step; stop = 0;

        // saturation and preset rewrite during RUN
        ev_clr = 1; step; ev_clr = 0;
        check("t5_ev0",  32'(event_count), 'h0);
        check("t5_ovr0", 32'(overrun), 'h0);
        preset_we = 1; preset_in = 8'hFE; step; preset_we = 0;
        start = 1; step; start = 0;
        step;
        check("t5_q0", 32'(bus.cnt_q), 'hFE);
        for (int i = 1; i <= 5; i++) begin
            step;
            check("t5_qff", 32'(bus.cnt_q), 'hFF);
            step;
            check("t5_qfe", 32'(bus.cnt_q), 'hFE);
            check("t5_tcp", 32'(tc_pulse), 'h1);
            check("t5_ev",  32'(event_count), (i > 3) ? 3 : i);
            check("t5_ovr", 32'(overrun), (i > 3) ? 1 : 0);
        end
        preset_we = 1; preset_in = 8'hFC; step; preset_we = 0;
        check("t5_old_q", 32'(bus.cnt_q), 'hFF);
        check("t5_new_d", 32'(bus.cnt_d), 'hFC);
        ev_clr = 1; step; ev_clr = 0;
        check("t5_new_q",  32'(bus.cnt_q), 'hFC);
        check("t5_clr_ev", 32'(event_count), 'h1);
        check("t5_clr_ov", 32'(overrun), 'h0);
        step;
        check("t5_q_fd", 32'(bus.cnt_q), 'hFD);
        stop = 1; step; stop = 0;

        // load fault, then reset mid-RUN
        preset_we = 1; preset_in = 8'h80; step; preset_we = 0;
        start = 1; step; start = 0;
        force_zero = 1; step;
        check("t6_q_forced", 32'(bus.cnt_q), 'h00);
        step; force_zero = 0;
        check("t6_lerr", 32'(load_err), 'h1);
        step;
        check("t6_lerr_sticky", 32'(load_err), 'h1);
        check("t6_pre_busy",    32'(busy), 'h1);
        CLR_n = 0; #1;
        check("t6_busy",  32'(busy), 'h0);
        check("t6_enp",   32'(bus.cnt_enp), 'h0);
        check("t6_ent",   32'(bus.cnt_ent), 'h0);
        check("t6_ldn",   32'(bus.cnt_load_n), 'h1);
        check("t6_ev",    32'(event_count), 'h0);
        check("t6_lerr0", 32'(load_err), 'h0);
        check("t6_d",     32'(bus.cnt_d), 'h0);
        #3 CLR_n = 1;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
